// File: rtl/matvec_seq_ctrl.sv
// matvec_seq_ctrl: load/settle/drain sequencer for a 4x4 fp16 mat-vec datapath.
// Optional matrix reuse compiled in with `define MATVEC_MAT_REUSE_EN.
module matvec_seq_ctrl #(
  parameter int DATA_W        = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 reuse_mat,
  output logic [16*DATA_W-1:0] mat_flat,
  output logic [4*DATA_W-1:0]  vec_flat,
  input  logic [4*DATA_W-1:0]  prod_flat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_last,
  output logic                 busy
);

  typedef enum logic [1:0] {
    LOAD,
    WAIT,
    DRAIN
  } state_t;

  localparam logic [3:0] WLAST = 4'(SETTLE_CYCLES - 1);

  state_t            state;
  logic [4:0]        cnt;
  logic [3:0]        wcnt;
  logic [1:0]        idx;
  logic [DATA_W-1:0] mat_q [16];
  logic [DATA_W-1:0] vec_q [4];
  logic [DATA_W-1:0] res_q [4];
  logic [DATA_W-1:0] prod  [4];
  logic              accept;
  logic              reuse_hit;

  assign accept = in_valid & in_ready;

  for (genvar g = 0; g < 16; g++) begin : g_mat
    assign mat_flat[g*DATA_W +: DATA_W] = mat_q[g];
  end

  for (genvar g = 0; g < 4; g++) begin : g_vec
    assign vec_flat[g*DATA_W +: DATA_W] = vec_q[g];
    assign prod[g] = prod_flat[g*DATA_W +: DATA_W];
  end

`ifdef MATVEC_MAT_REUSE_EN
  logic mat_loaded;

  // A job may skip the matrix only once a full matrix is held.
  assign reuse_hit = (cnt == 5'd0) & reuse_mat & mat_loaded;

  always_ff @(posedge clk) begin
    if (rst) begin
      mat_loaded <= 1'b0;
    end else if (accept && !reuse_hit && cnt == 5'd15) begin
      mat_loaded <= 1'b1;
    end
  end
`else
  logic unused_reuse;

  assign unused_reuse = reuse_mat;
  assign reuse_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= 5'd0;
      wcnt      <= 4'd0;
      idx       <= 2'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < 16; i++) mat_q[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        vec_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      unique case (state)
        LOAD: begin
          if (accept) begin
            busy <= 1'b1;
            if (reuse_hit) begin
              vec_q[0] <= in_data;
              cnt      <= 5'd17;
            end else begin
              if (cnt < 5'd16) mat_q[cnt[3:0]] <= in_data;
              else             vec_q[cnt[1:0]] <= in_data;
              if (cnt == 5'd19) begin
                state    <= WAIT;
                cnt      <= 5'd0;
                wcnt     <= 4'd0;
                in_ready <= 1'b0;
              end else begin
                cnt <= cnt + 5'd1;
              end
            end
          end
        end
        WAIT: begin
          if (wcnt == WLAST) begin
            for (int i = 0; i < 4; i++) res_q[i] <= prod[i];
            state     <= DRAIN;
            idx       <= 2'd0;
            out_valid <= 1'b1;
            out_data  <= prod[0];
            out_last  <= 1'b0;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (idx == 2'd3) begin
              state     <= LOAD;
              idx       <= 2'd0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              idx      <= idx + 2'd1;
              out_data <= res_q[idx + 2'd1];
              out_last <= (idx == 2'd2);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_seq_ctrl.sv
// tb_matvec_seq_ctrl: table-driven jobs with an fp16 datapath model
// and an expected-result queue, plus reset and reuse sequences.
module tb_matvec_seq_ctrl;

  localparam int DW = 16;
  localparam int SC = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic           reuse_mat;
  logic [16*DW-1:0] mat_flat;
  logic [4*DW-1:0]  vec_flat;
  logic [4*DW-1:0]  prod_flat;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic           out_last;
  logic           busy;

  always #5 clk = ~clk;

  matvec_seq_ctrl #(
    .DATA_W       (DW),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .reuse_mat(reuse_mat),
    .mat_flat (mat_flat),
    .vec_flat (vec_flat),
    .prod_flat(prod_flat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  function automatic real h2r(input logic [15:0] h);
    int  e;
    real f;
    e = int'(h[14:10]);
    f = real'(h[9:0]);
    if (e == 0) f = f / 1024.0 * (2.0 ** (-14));
    else        f = (1.0 + f / 1024.0) * (2.0 ** (e - 15));
    return h[15] ? -f : f;
  endfunction

  function automatic logic [15:0] r2h(input real x);
    real  a;
    int   e;
    int   m;
    logic s;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    a = s ? -x : x;
    e = 15;
    while (a >= 2.0 && e < 30) begin a = a / 2.0; e++; end
    while (a < 1.0 && e > 1) begin a = a * 2.0; e--; end
    m = int'((a - 1.0) * 1024.0);
    if (m >= 1024) begin m = 0; e++; end
    return {s, 5'(e), 10'(m)};
  endfunction

  function automatic logic [63:0] dp(input logic [255:0] m,
                                     input logic [63:0] v);
    logic [63:0] r;
    real acc;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      acc = 0.0;
      for (int c = 0; c < 4; c++)
        acc += h2r(m[(4*i+c)*16 +: 16]) * h2r(v[c*16 +: 16]);
      r[i*16 +: 16] = r2h(acc);
    end
    return r;
  endfunction

  assign prod_flat = dp(mat_flat, vec_flat);

  typedef struct {
    string             name;
    logic [19:0][15:0] w;
    logic [3:0][15:0]  exp;
    logic [6:0]        rdy;
    bit                gaps;
  } job_t;

  job_t        jobs[6];
  logic [15:0] sb[$];
  logic [15:0] em[20];
  int          total  = 0;
  int          passed = 0;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic chkw(input string n, input logic [319:0] a,
                      input logic [319:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  function automatic logic [319:0] em_pack();
    logic [319:0] r;
    for (int i = 0; i < 20; i++) r[i*16 +: 16] = em[i];
    return r;
  endfunction

  task automatic check_store(input string n);
    chkw(n, {vec_flat, mat_flat}, em_pack());
  endtask

  task automatic clear_em();
    for (int i = 0; i < 20; i++) em[i] = 16'h0000;
  endtask

  function automatic logic [15:0][15:0] ident(input logic [15:0] d);
    logic [15:0][15:0] m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[4*r+c] = (r == c) ? d : 16'h0000;
    return m;
  endfunction

  function automatic logic [15:0][15:0] fill(input logic [15:0] d);
    logic [15:0][15:0] m;
    for (int i = 0; i < 16; i++) m[i] = d;
    return m;
  endfunction

  function automatic logic [15:0][15:0] anti();
    logic [15:0][15:0] m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[4*r+c] = (c == 3 - r) ? 16'h3C00 : 16'h0000;
    return m;
  endfunction

  function automatic logic [19:0][15:0] mk(input logic [15:0][15:0] m,
                                           input logic [3:0][15:0] v);
    logic [19:0][15:0] w;
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 0; i < 4; i++) w[16+i] = v[i];
    return w;
  endfunction

  task automatic push_exp(input logic [3:0][15:0] e);
    for (int i = 0; i < 4; i++) sb.push_back(e[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0][15:0] w, input int first,
                      input int n, input bit gaps, input bit reuse);
    for (int i = first; i < first + n; i++) begin
      if (gaps && i > first) begin
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        tick();
        check_store("gap_store");
      end
      in_valid  = 1'b1;
      in_data   = w[i];
      reuse_mat = (i == first) ? reuse : 1'b0;
      em[i]     = w[i];
      tick();
    end
    in_valid  = 1'b0;
    reuse_mat = 1'b0;
  endtask

  task automatic drain(input logic [6:0] rdy, input bit chk_lat);
    int          waits = 0;
    int          got = 0;
    int          k = 0;
    int          budget = 40;
    bit          stalled = 0;
    logic [15:0] held = 16'h0;
    logic [15:0] e;
    while (!out_valid && waits < 50) begin
      tick();
      waits++;
    end
    if (chk_lat) chk("latency", 64'(waits + 1), 64'(SC + 1));
    while (got < 4 && budget > 0) begin
      if (out_valid) begin
        out_ready = (k < 7) ? rdy[k] : 1'b1;
        k++;
        chk("in_ready_drain", 64'(in_ready), 64'(0));
        if (stalled) chk("stall_stable", 64'(out_data), 64'(held));
        if (out_ready) begin
          e = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
          chk("out_data", 64'(out_data), 64'(e));
          chk("out_last", 64'(out_last), 64'(got == 3));
          got++;
          stalled = 0;
        end else begin
          held    = out_data;
          stalled = 1;
        end
      end else begin
        out_ready = 1'b0;
      end
      tick();
      budget--;
    end
    out_ready = 1'b0;
    if (got < 4) chk("drain_timeout", 64'(got), 64'(4));
    chk("in_ready_after", 64'(in_ready), 64'(1));
    chk("busy_after", 64'(busy), 64'(0));
    check_store("store_after_job");
  endtask

  task automatic run_job(input job_t j);
    push_exp(j.exp);
    send(j.w, 0, 20, j.gaps, 1'b0);
    drain(j.rdy, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_em();
    sb.delete();
  endtask

  logic [3:0][15:0]  v1234;
  logic [19:0][15:0] w2;
  int                wt;

  initial begin
    v1234 = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
    jobs[0] = '{"identity", mk(ident(16'h3C00), v1234),
                v1234, 7'h7F, 1'b0};
    jobs[1] = '{"stall", mk(ident(16'h3C00), v1234),
                v1234, 7'b1101001, 1'b0};
    jobs[2] = '{"gaps", mk(ident(16'h3C00), v1234),
                v1234, 7'h7F, 1'b1};
    jobs[3] = '{"diag2", mk(ident(16'h4000), v1234),
                {16'h4800, 16'h4600, 16'h4400, 16'h4000}, 7'h7F, 1'b0};
    jobs[4] = '{"ones", mk(fill(16'h3C00), v1234),
                {16'h4900, 16'h4900, 16'h4900, 16'h4900}, 7'h7F, 1'b0};
    jobs[5] = '{"anti", mk(anti(), v1234),
                {16'h3C00, 16'h4000, 16'h4200, 16'h4400}, 7'b0101010, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    reuse_mat = 1'b0;
    out_ready = 1'b0;
    clear_em();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    check_store("rst_store");

    foreach (jobs[i]) run_job(jobs[i]);

    send(jobs[0].w, 0, 10, 1'b0, 1'b0);
    chk("busy_mid_load", 64'(busy), 64'(1));
    do_reset();
    check_store("rst_mid_load_store");
    chk("rst_mid_load_busy", 64'(busy), 64'(0));
    chk("rst_mid_load_ready", 64'(in_ready), 64'(1));
    run_job(jobs[3]);

    send(jobs[4].w, 0, 20, 1'b0, 1'b0);
    wt = 0;
    while (!out_valid && wt < 20) begin tick(); wt++; end
    chk("pre_drain_valid", 64'(out_valid), 64'(1));
    do_reset();
    chk("rst_drain_valid", 64'(out_valid), 64'(0));
    chk("rst_drain_data", 64'(out_data), 64'(0));
    chk("rst_drain_ready", 64'(in_ready), 64'(1));
    check_store("rst_drain_store");

    push_exp(jobs[0].exp);
    send(jobs[0].w, 0, 4, 1'b0, 1'b1);
    chk("reuse_after_rst_ready", 64'(in_ready), 64'(1));
    send(jobs[0].w, 4, 16, 1'b0, 1'b0);
    drain(7'h7F, 1'b1);

    w2 = mk(ident(16'h3C00), {4{16'h4000}});
    push_exp({4{16'h4000}});
`ifdef MATVEC_MAT_REUSE_EN
    send(w2, 16, 4, 1'b0, 1'b1);
    chk("reuse_wait_ready", 64'(in_ready), 64'(0));
    chk("reuse_busy", 64'(busy), 64'(1));
    check_store("reuse_store");
`else
    send(w2, 0, 4, 1'b0, 1'b1);
    chk("noreuse_ready", 64'(in_ready), 64'(1));
    send(w2, 4, 16, 1'b0, 1'b0);
`endif
    drain(7'h7F, 1'b1);
    run_job(jobs[4]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
